// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side definitions: widths, boot address, NOP encoding
// and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam int          WORD_SIZE = 32;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INC    = 4;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2,
        KILL     = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register shared by fetch_stage and decode_stage.
// Priority: flush, then load, then hold; otherwise a bubble is inserted.
module fd_pipeline_reg
    import fetch_stage_pkg::*;
#(
    parameter int W = WORD_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] instr_in,
    input  logic [W-1:0] pc_in,
    output logic [W-1:0] instruction,
    output logic [W-1:0] pc_out,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction <= W'(NOP_INSTR);
            pc_out      <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= W'(NOP_INSTR);
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= instr_in;
            pc_out      <= pc_in;
            valid       <= 1'b1;
        end else if (!hold) begin
            valid       <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, icache request/ready handshake, stall hold buffer
// and jump redirect, feeding the F/D register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                   WORD_SIZE = fetch_stage_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR = WORD_SIZE'(fetch_stage_pkg::BOOT_ADDR),
    parameter int                   PC_INC    = fetch_stage_pkg::PC_INC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 jump_taken,
    input  logic [WORD_SIZE-1:0] jump_target,
    output logic                 icache_req,
    output logic [WORD_SIZE-1:0] icache_addr,
    input  logic                 icache_ready,
    input  logic [WORD_SIZE-1:0] icache_data,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 valid
);

    localparam int AW = WORD_SIZE - 2;

    fetch_state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [WORD_SIZE-1:0] hb_data_q, hb_data_d;
    logic [AW-1:0] hb_pc_q, hb_pc_d;
    logic hb_valid_q, hb_valid_d;

    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pc_inc;
    logic fd_load, fd_hold, fd_flush;
    logic [WORD_SIZE-1:0] fd_instr, fd_pc;
    logic unused_bits;

    assign pc          = {pc_q, 2'b00};
    assign pc_inc      = pc + WORD_SIZE'(PC_INC);
    assign icache_addr = pc;
    assign unused_bits = ^{jump_target[1:0], pc_inc[1:0]};

    // No request while in reset, in HOLD, or in FETCH under stall.
    assign icache_req = rst &&
        ((state_q == WAIT_MEM) || (state_q == KILL) ||
         (state_q == FETCH && !stall_in));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= BOOT_ADDR[WORD_SIZE-1:2];
            tgt_q      <= '0;
            hb_data_q  <= '0;
            hb_pc_q    <= '0;
            hb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            hb_data_q  <= hb_data_d;
            hb_pc_q    <= hb_pc_d;
            hb_valid_q <= hb_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        hb_data_d  = hb_data_q;
        hb_pc_d    = hb_pc_q;
        hb_valid_d = hb_valid_q;
        fd_load    = 1'b0;
        fd_hold    = 1'b0;
        fd_flush   = 1'b0;
        fd_instr   = icache_data;
        fd_pc      = pc;
        if (jump_taken) begin
            fd_flush   = 1'b1;
            hb_valid_d = 1'b0;
            case (state_q)
                // Outstanding miss must drain before redirecting.
                WAIT_MEM: begin
                    tgt_d   = jump_target[WORD_SIZE-1:2];
                    state_d = KILL;
                end
                KILL: begin
                    tgt_d = jump_target[WORD_SIZE-1:2];
                    if (icache_ready) begin
                        pc_d    = jump_target[WORD_SIZE-1:2];
                        state_d = FETCH;
                    end
                end
                default: begin
                    pc_d    = jump_target[WORD_SIZE-1:2];
                    state_d = FETCH;
                end
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (stall_in) begin
                        fd_hold = 1'b1;
                    end else if (icache_ready) begin
                        fd_load = 1'b1;
                        pc_d    = pc_inc[WORD_SIZE-1:2];
                    end else begin
                        state_d = WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    fd_hold = stall_in;
                    if (icache_ready) begin
                        pc_d = pc_inc[WORD_SIZE-1:2];
                        if (stall_in) begin
                            hb_data_d  = icache_data;
                            hb_pc_d    = pc_q;
                            hb_valid_d = 1'b1;
                            state_d    = HOLD;
                        end else begin
                            fd_load = 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (stall_in) begin
                        fd_hold = 1'b1;
                    end else begin
                        fd_load    = hb_valid_q;
                        fd_instr   = hb_data_q;
                        fd_pc      = {hb_pc_q, 2'b00};
                        hb_valid_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    fd_hold = stall_in;
                    if (icache_ready) begin
                        pc_d    = tgt_q;
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    fd_pipeline_reg #(
        .W (WORD_SIZE)
    ) u_fd_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (fd_load),
        .hold        (fd_hold),
        .flush       (fd_flush),
        .instr_in    (fd_instr),
        .pc_in       (fd_pc),
        .instruction (instruction),
        .pc_out      (pc_out),
        .valid       (valid)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end stage directly upstream of decode_stage.
- Holds the PC, requests instructions from the instruction cache, and handles cache misses with a request/ready handshake.
- Drives the fetch/decode pipeline register (instruction, pc, valid) consumed by decode_stage.
- Obeys decode's stall_out (wired to this block's stall_in) and redirects on jump_taken.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): instruction/address width.
- BOOT_ADDR, 32'h0000_1000: PC value after reset.
- PC_INC, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- stall_in  in  1  decode cannot accept; hold F/D register
- jump_taken  in  1  redirect request from execute; flushes fetch
- jump_target  in  WORD_SIZE  redirect PC, word aligned
- icache_req  out  1  fetch request valid
- icache_addr  out  WORD_SIZE  fetch address; stable while request outstanding
- icache_ready  in  1  icache_data valid for icache_addr (same cycle on hit, later on miss)
- icache_data  in  WORD_SIZE  instruction word
- instruction  out  WORD_SIZE  F/D register: instruction to decode
- pc_out  out  WORD_SIZE  F/D register: PC of instruction
- valid  out  1  F/D register: instruction valid

Behaviour:
- Reset (rst=0, async):
  - pc=BOOT_ADDR, state=FETCH, valid=0, instruction=32'h0000_0013 (NOP), pc_out=0, hold buffer empty.
  - icache_req=0 during reset; first request occurs the cycle after rst rises.
- icache_addr always equals pc. icache_req=1 in FETCH and WAIT_MEM; 0 in HOLD, and 0 in FETCH while stall_in=1.
- States:
  - FETCH:
    - If icache_ready=1 and stall_in=0, then at the edge: F/D <= {icache_data, pc, 1}; pc += PC_INC. Hit latency is 1 cycle, giving 1 instruction/cycle.
    - If icache_ready=0, go to WAIT_MEM; F/D valid<=0 unless stalled.
  - WAIT_MEM:
    - pc and icache_addr are held.
    - On icache_ready with stall_in=0: load F/D, pc += PC_INC, go to FETCH.
    - On icache_ready with stall_in=1: capture the word and its pc in the hold buffer, pc += PC_INC, go to HOLD.
  - HOLD:
    - No request.
    - When stall_in=0: F/D <= hold buffer, valid=1, go to FETCH.
  - KILL:
    - Entered on jump_taken while in WAIT_MEM. Address is held until icache_ready, then the returned word is discarded.
    - Next cycle: pc=saved target, state FETCH.
- stall_in=1 (not jumping): F/D register holds all fields unchanged, including valid. pc does not advance.
- jump_taken (highest priority, overrides stall_in):
  - Every state: F/D valid<=0, instruction<=NOP, hold buffer cleared.
  - FETCH/HOLD: pc<=jump_target, state FETCH; any same-cycle icache_data is dropped.
  - WAIT_MEM: save jump_target, state KILL.
  - KILL: a further jump_taken overwrites the saved target.
- pc arithmetic is modulo 2^WORD_SIZE; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Only pc[WORD_SIZE-1:2] is registered; bits [1:0] are always 0.
- icache_ready in HOLD or in FETCH while stall_in=1 (no request) is ignored.

Decomposition:
- Shared defines file:
  - `WORD_SIZE, `BOOT_ADDR, `NOP_INSTR (32'h0000_0013).
  - Fetch state encoding (2-bit: FETCH, WAIT_MEM, HOLD, KILL).
- One sub-module, fd_pipeline_reg: the F/D register with load, hold and flush inputs and async active-low reset. decode_stage also consumes it.
- PC/FSM logic stays in fetch_stage.

Test Plan:
1. Reset release, icache_ready tied 1, icache_data=addr: valid rises the cycle after first request; pc_out sequence 0x1000, 0x1004, 0x1008 on consecutive cycles.
2. Miss: at pc 0x1008, hold icache_ready=0 for 3 cycles → icache_addr stays 0x1008, valid=0. On ready → instruction=data, pc_out=0x1008 next cycle, then 0x100C.
3. Stall: stall_in=1 for 2 cycles with pc_out=0x1004 valid → F/D unchanged, icache_req=0. Release → next pc_out=0x1008.
4. Miss data arriving under stall → HOLD entered, icache_req=0. Stall drops → the buffered word appears with correct pc, no instruction lost or duplicated.
5. jump_taken with target 0x2000 during WAIT_MEM at 0x1010 → valid=0, address held until ready, returned word not presented. Next request is 0x2000, first valid pc_out=0x2000.
6. jump_taken and stall_in both 1 → flush wins: valid=0, pc=target. Async reset mid-WAIT_MEM → immediate valid=0, icache_req=0, pc=0x1000.
